fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a one-entry stall skid buffer and redirect kill.
// Defining FETCH_PERF_EN adds the FetchCount/WaitCount performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic        Jump,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] InstructionOut,
    output logic [31:0] PCAdderOut,
    output logic        Valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] WaitCount
`endif
);

    typedef enum logic [1:0] {RUN, KILL, HOLD} state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d, pc_plus4;
    logic [31:0] skid_instr, skid_instr_d;
    logic [31:0] skid_pc, skid_pc_d;
    logic [31:0] saved_target, saved_target_d;
    logic [31:0] instr_d, pcadd_d;
    logic        valid_d;
    logic        redirect;
    logic [31:0] target;

    // Redirects are only honoured when decode is not stalled; Jump wins over a branch.
    assign redirect = !Stall && (Jump || BranchTaken);
    assign target   = Jump ? JumpTarget : BranchTarget;
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d        = state;
        pc_d           = pc;
        skid_instr_d   = skid_instr;
        skid_pc_d      = skid_pc;
        saved_target_d = saved_target;
        instr_d        = InstructionOut;
        pcadd_d        = PCAdderOut;
        valid_d        = Valid;
        IMemReq        = 1'b1;
        IMemAddr       = pc;

        case (state)
            RUN: begin
                if (redirect) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                    if (IMemReady) begin
                        pc_d = target;
                    end else begin
                        saved_target_d = target;
                        state_d        = KILL;
                    end
                end else if (!Stall) begin
                    if (IMemReady) begin
                        instr_d = IMemData;
                        pcadd_d = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end else begin
                        instr_d = '0;
                        valid_d = 1'b0;
                    end
                end else if (IMemReady) begin
                    skid_instr_d = IMemData;
                    skid_pc_d    = pc_plus4;
                    state_d      = HOLD;
                end
            end

            KILL: begin
                // The outstanding read still has to drain, even while decode is stalled.
                if (redirect) saved_target_d = target;
                if (!Stall) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                end
                if (IMemReady) begin
                    pc_d    = redirect ? target : saved_target;
                    state_d = RUN;
                end
            end

            HOLD: begin
                IMemReq = 1'b0;
                if (!Stall) begin
                    state_d = RUN;
                    if (redirect) begin
                        instr_d = '0;
                        valid_d = 1'b0;
                        pc_d    = target;
                    end else begin
                        instr_d = skid_instr;
                        pcadd_d = skid_pc;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end
            end

            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!Rst_n) begin
            state          <= RUN;
            pc             <= RESET_PC;
            skid_instr     <= '0;
            skid_pc        <= '0;
            saved_target   <= '0;
            InstructionOut <= '0;
            PCAdderOut     <= '0;
            Valid          <= 1'b0;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            skid_instr     <= skid_instr_d;
            skid_pc        <= skid_pc_d;
            saved_target   <= saved_target_d;
            InstructionOut <= instr_d;
            PCAdderOut     <= pcadd_d;
            Valid          <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic accept;

    // An instruction is accepted when a fresh word or the skid entry goes out as valid.
    assign accept = !Stall && !redirect && ((state == RUN && IMemReady) || state == HOLD);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            FetchCount <= '0;
            WaitCount  <= '0;
        end else begin
            if (accept) FetchCount <= FetchCount + 32'd1;
            if (state == RUN && !IMemReady) WaitCount <= WaitCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand-written reset/wrap sequences and a
// randomized run checked against a queue-based behavioural model of fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken, jump, imem_ready;
    logic [31:0] branch_target, jump_target, imem_data;

    logic        req0, valid0, req1, valid1;
    logic [31:0] addr0, instr0, pcadd0, addr1, instr1, pcadd1;
`ifdef FETCH_PERF_EN
    logic [31:0] fc0, wc0, fc1, wc1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut0 (
        .Clk(clk), .Rst_n(rst_n), .Stall(stall), .BranchTaken(branch_taken), .Jump(jump),
        .BranchTarget(branch_target), .JumpTarget(jump_target),
        .IMemReq(req0), .IMemAddr(addr0), .IMemReady(imem_ready), .IMemData(imem_data),
        .InstructionOut(instr0), .PCAdderOut(pcadd0), .Valid(valid0)
`ifdef FETCH_PERF_EN
        , .FetchCount(fc0), .WaitCount(wc0)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .Stall(stall), .BranchTaken(branch_taken), .Jump(jump),
        .BranchTarget(branch_target), .JumpTarget(jump_target),
        .IMemReq(req1), .IMemAddr(addr1), .IMemReady(imem_ready), .IMemData(imem_data),
        .InstructionOut(instr1), .PCAdderOut(pcadd1), .Valid(valid1)
`ifdef FETCH_PERF_EN
        , .FetchCount(fc1), .WaitCount(wc1)
`endif
    );

    typedef struct {
        logic        rst_n, stall, br, jmp;
        logic [31:0] bt, jt;
        logic        rdy;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr, e_instr, e_pcadd;
        logic        e_valid;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic r, s, b, j, input logic [31:0] bt, jt,
                                input logic rd, input logic [31:0] d, input logic er,
                                input logic [31:0] ea, ei, ep, input logic ev);
        vec_t v;
        v.rst_n = r; v.stall = s; v.br = b; v.jmp = j; v.bt = bt; v.jt = jt;
        v.rdy = rd; v.data = d; v.e_req = er; v.e_addr = ea; v.e_instr = ei;
        v.e_pcadd = ep; v.e_valid = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, b, j, input logic [31:0] bt, jt,
                         input logic rd, input logic [31:0] d);
        rst_n = r; stall = s; branch_taken = b; jump = j;
        branch_target = bt; jump_target = jt; imem_ready = rd; imem_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: pending skid entries and pending kill targets kept as queues.
    logic [31:0] m_pc, m_instr, m_pcadd;
    logic        m_valid;
    logic [63:0] skid_q[$];
    logic [31:0] kill_q[$];

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        redir = !stall && (jump || branch_taken);
        tgt   = jump ? jump_target : branch_target;
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pcadd = 32'h0; m_valid = 1'b0;
            skid_q.delete(); kill_q.delete();
        end else if (kill_q.size() != 0) begin
            if (redir) kill_q[0] = tgt;
            if (!stall) begin m_instr = 32'h0; m_valid = 1'b0; end
            if (imem_ready) m_pc = kill_q.pop_front();
        end else if (skid_q.size() != 0) begin
            if (!stall) begin
                if (redir) begin
                    void'(skid_q.pop_front());
                    m_instr = 32'h0; m_valid = 1'b0; m_pc = tgt;
                end else begin
                    {m_instr, m_pcadd} = skid_q.pop_front();
                    m_valid = 1'b1; m_pc = m_pc + 32'd4;
                end
            end
        end else if (!stall) begin
            if (redir) begin
                m_instr = 32'h0; m_valid = 1'b0;
                if (imem_ready) m_pc = tgt;
                else kill_q.push_back(tgt);
            end else if (imem_ready) begin
                m_instr = imem_data; m_pcadd = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end else begin
                m_instr = 32'h0; m_valid = 1'b0;
            end
        end else if (imem_ready) begin
            skid_q.push_back({imem_data, m_pc + 32'd4});
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        //            rst st br jp bt       jt       rdy data          req addr     instr         pcadd    v
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   1, 32'hEEEE_0000, 1, 32'h0,   32'h0,        32'h0,   0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hA000_0001, 1, 32'h4,   32'hA000_0001, 32'h4,  1);
        vecs[2]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hA000_0002, 1, 32'h8,   32'hA000_0002, 32'h8,  1);
        vecs[3]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hA000_0003, 1, 32'hC,   32'hA000_0003, 32'hC,  1);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,         1, 32'h0,   32'h0,        32'h0,   0);
        vecs[5]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hB000_0001, 1, 32'h4,   32'hB000_0001, 32'h4,  1);
        vecs[6]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hB000_0002, 1, 32'h8,   32'hB000_0002, 32'h8,  1);
        vecs[7]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,         1, 32'h8,   32'h0,        32'h8,   0);
        vecs[8]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,         1, 32'h8,   32'h0,        32'h8,   0);
        vecs[9]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hB000_0003, 1, 32'hC,   32'hB000_0003, 32'hC,  1);
        vecs[10] = mk(1, 0, 0, 1, 32'h0,   32'h40,  0, 32'h0,         1, 32'hC,   32'h0,        32'hC,   0);
        vecs[11] = mk(1, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,         1, 32'hC,   32'h0,        32'hC,   0);
        vecs[12] = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hDEAD_DEAD, 1, 32'h40,  32'h0,        32'hC,   0);
        vecs[13] = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hB000_0004, 1, 32'h44,  32'hB000_0004, 32'h44, 1);
        vecs[14] = mk(1, 0, 1, 0, 32'h10,  32'h0,   1, 32'hBAD0_0000, 1, 32'h10,  32'h0,        32'h44,  0);
        vecs[15] = mk(1, 1, 0, 0, 32'h0,   32'h0,   1, 32'hB000_0005, 0, 32'h0,   32'h0,        32'h44,  0);
        vecs[16] = mk(1, 1, 0, 0, 32'h0,   32'h0,   0, 32'h0,         0, 32'h0,   32'h0,        32'h44,  0);
        vecs[17] = mk(1, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0,         1, 32'h14,  32'hB000_0005, 32'h14, 1);
        vecs[18] = mk(1, 1, 0, 0, 32'h0,   32'h0,   0, 32'h0,         1, 32'h14,  32'hB000_0005, 32'h14, 1);
        vecs[19] = mk(1, 1, 0, 1, 32'h0,   32'h80,  0, 32'h0,         1, 32'h14,  32'hB000_0005, 32'h14, 1);
        vecs[20] = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hB000_0006, 1, 32'h18,  32'hB000_0006, 32'h18, 1);
        vecs[21] = mk(1, 1, 0, 0, 32'h0,   32'h0,   1, 32'hB000_0007, 0, 32'h0,   32'hB000_0006, 32'h18, 1);
        vecs[22] = mk(1, 0, 1, 1, 32'h200, 32'h100, 0, 32'h0,         1, 32'h100, 32'h0,        32'h18,  0);
        vecs[23] = mk(1, 0, 1, 0, 32'h300, 32'h0,   0, 32'h0,         1, 32'h100, 32'h0,        32'h18,  0);
        vecs[24] = mk(1, 0, 0, 1, 32'h0,   32'h400, 0, 32'h0,         1, 32'h100, 32'h0,        32'h18,  0);
        vecs[25] = mk(1, 1, 0, 1, 32'h0,   32'h500, 1, 32'hBAD1_0000, 1, 32'h400, 32'h0,        32'h18,  0);
        vecs[26] = mk(1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hB000_0008, 1, 32'h404, 32'hB000_0008, 32'h404, 1);

        tick();
        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].jmp, vecs[i].bt, vecs[i].jt,
                  vecs[i].rdy, vecs[i].data);
            tick();
            check($sformatf("v%0d.req", i), req0, vecs[i].e_req);
            if (vecs[i].e_req) check($sformatf("v%0d.addr", i), addr0, vecs[i].e_addr);
            check($sformatf("v%0d.instr", i), instr0, vecs[i].e_instr);
            check($sformatf("v%0d.pcadd", i), pcadd0, vecs[i].e_pcadd);
            check($sformatf("v%0d.valid", i), valid0, vecs[i].e_valid);
        end

        // Wrap from RESET_PC = 0xFFFFFFFC, then reset while a kill is draining.
        drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        check("wrap.reset_addr", addr1, 32'hFFFF_FFFC);
        check("wrap.reset_valid", valid1, 1'b0);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 1, 32'hC000_0001);
        tick();
        check("wrap.pcadd", pcadd1, 32'h0);
        check("wrap.instr", instr1, 32'hC000_0001);
        check("wrap.valid", valid1, 1'b1);
        check("wrap.addr", addr1, 32'h0);
        drive(1, 0, 0, 1, 32'h0, 32'h40, 0, 32'h0);
        tick();
        check("kill.addr_old", addr1, 32'h0);
        check("kill.valid", valid1, 1'b0);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hC000_0002);
        tick();
        check("kill_rst.addr", addr1, 32'hFFFF_FFFC);
        check("kill_rst.req", req1, 1'b1);
        check("kill_rst.valid", valid1, 1'b0);
        check("kill_rst.instr", instr1, 32'h0);
        check("kill_rst.pcadd", pcadd1, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 1, 32'hC000_0003);
        tick();
        check("post_rst.instr", instr1, 32'hC000_0003);
        check("post_rst.pcadd", pcadd1, 32'h0);
        check("post_rst.valid", valid1, 1'b1);

        // Randomized run against the behavioural model.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] bt_r, jt_r;
            bt_r = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            jt_r = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive((c == 0 || $urandom_range(63) == 0) ? 1'b0 : 1'b1,
                  $urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
                  bt_r, jt_r, $urandom_range(1) == 1, $urandom);
            model_step();
            tick();
            check($sformatf("rnd%0d.req", c), req0, (skid_q.size() == 0));
            if (skid_q.size() == 0) check($sformatf("rnd%0d.addr", c), addr0, m_pc);
            check($sformatf("rnd%0d.instr", c), instr0, m_instr);
            check($sformatf("rnd%0d.pcadd", c), pcadd0, m_pcadd);
            check($sformatf("rnd%0d.valid", c), valid0, m_valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
